// File: rtl/num_char_encoder_pkg.sv
// Shared types for the numeric word encoder: character classes, terminator kinds, ASCII constants, FSM states.
// NUM_CHAR_ENCODER_CRLF_EN adds the TERM_LF state used for "\r\n" line endings.
package num_char_encoder_pkg;

  typedef enum logic [3:0] {
    CT_UNKNOWN, CT_G, CT_X, CT_Y, CT_I, CT_J, CT_F,
    CT_DIGIT, CT_MINUS, CT_SPACE, CT_DOT, CT_NEWLINE
  } Char_t;

  typedef enum logic [1:0] {TERM_NONE, TERM_SPACE, TERM_NEWLINE} CharTerm_t;

  localparam logic [7:0] CHAR_MINUS = 8'd45;
  localparam logic [7:0] CHAR_SPACE = 8'd32;
  localparam logic [7:0] CHAR_LF    = 8'd10;
  localparam logic [7:0] CHAR_CR    = 8'd13;
  localparam logic [7:0] CHAR_ZERO  = 8'd48;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CONVERT, ST_PREFIX, ST_SIGN, ST_DIGIT, ST_TERM
`ifdef NUM_CHAR_ENCODER_CRLF_EN
    , ST_TERM_LF
`endif
  } enc_state_e;

  // Same classification the decoder applies on the receive side.
  function automatic Char_t char_class(input logic [7:0] c);
    Char_t t;
    t = CT_UNKNOWN;
    case (c)
      8'h47: t = CT_G;
      8'h58: t = CT_X;
      8'h59: t = CT_Y;
      8'h49: t = CT_I;
      8'h4A: t = CT_J;
      8'h46: t = CT_F;
      8'h2D: t = CT_MINUS;
      8'h20: t = CT_SPACE;
      8'h2E: t = CT_DOT;
      8'h0A: t = CT_NEWLINE;
      default: if (c >= 8'h30 && c <= 8'h39) t = CT_DIGIT;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/num_char_encoder_if.sv
// Command and byte-stream handshake bundle for num_char_encoder.
interface num_char_encoder_if #(parameter int NUM_BITS = 16);
  import num_char_encoder_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [7:0]          prefix;
  logic [NUM_BITS-1:0] value;
  CharTerm_t           term;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          char_out;
  Char_t               char_type;
  logic                busy;

  modport master (
    output in_valid, prefix, value, term, out_ready,
    input  in_ready, out_valid, char_out, char_type, busy
  );

  modport slave (
    input  in_valid, prefix, value, term, out_ready,
    output in_ready, out_valid, char_out, char_type, busy
  );

endinterface

// File: rtl/num_char_encoder_bin2bcd.sv
// Iterative double-dabble: start loads the binary word, NUM_BITS shift cycles later done rises with DIGITS BCD nibbles.
module bin2bcd_iter #(
  parameter int NUM_BITS = 16,
  parameter int DIGITS   = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [NUM_BITS-1:0]   bin_i,
  output logic                  done_o,
  output logic [DIGITS*4-1:0]   bcd_o
);

  localparam int CW = $clog2(NUM_BITS + 1);
  localparam int DW = DIGITS * 4;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_BITS-1:0] bin_q, bin_d;
  logic [DW-1:0]       bcd_q, bcd_d, bcd_adj;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
    cnt_d = cnt_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    if (start_i) begin
      cnt_d = CW'(NUM_BITS);
      bin_d = bin_i;
      bcd_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      {bcd_d, bin_d} = {bcd_adj[DW-2:0], bin_q, 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      bin_q <= '0;
      bcd_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
    end
  end

  assign done_o = (cnt_q == '0);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/num_char_encoder.sv
// Serializes one signed G-code word (prefix, sign, decimal digits, terminator) as ASCII bytes, one per handshake.
// States: IDLE accept | CONVERT bin->bcd | PREFIX/SIGN/DIGIT/TERM emit bytes | TERM_LF '\n' after '\r' (NUM_CHAR_ENCODER_CRLF_EN).
module num_char_encoder
  import num_char_encoder_pkg::*;
#(
  parameter int NUM_BITS = 16,
  parameter int DIGITS   = 5
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  num_char_encoder_if.slave bus
);

  localparam int IW = $clog2(DIGITS);

  enc_state_e          state_q, state_d;
  logic [7:0]          prefix_q, prefix_d;
  CharTerm_t           term_q, term_d;
  logic                neg_q, neg_d;
  logic [IW-1:0]       idx_q, idx_d, first_idx;
  logic                conv_start, conv_done;
  logic [NUM_BITS-1:0] mag;
  logic [DIGITS*4-1:0] bcd;
  logic [3:0]          dig [DIGITS];
  logic                out_valid;
  logic [7:0]          char_out;

  // Two's-complement negate in NUM_BITS unsigned makes the most negative value come out exact.
  assign mag = bus.value[NUM_BITS-1] ? (~bus.value + NUM_BITS'(1)) : bus.value;

  bin2bcd_iter #(.NUM_BITS(NUM_BITS), .DIGITS(DIGITS)) u_bin2bcd (
    .clk_i   (clk_i),
    .rst_ni  (reset_ni),
    .start_i (conv_start),
    .bin_i   (mag),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );

  always_comb begin
    first_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig[i] = bcd[i*4 +: 4];
      if (bcd[i*4 +: 4] != 4'd0) first_idx = IW'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    prefix_d   = prefix_q;
    term_d     = term_q;
    neg_d      = neg_q;
    idx_d      = idx_q;
    conv_start = 1'b0;
    out_valid  = 1'b0;
    char_out   = 8'd0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          conv_start = 1'b1;
          prefix_d   = bus.prefix;
          term_d     = bus.term;
          neg_d      = bus.value[NUM_BITS-1];
          state_d    = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (conv_done) begin
          idx_d   = first_idx;
          state_d = (prefix_q != 8'd0) ? ST_PREFIX : (neg_q ? ST_SIGN : ST_DIGIT);
        end
      end
      ST_PREFIX: begin
        out_valid = 1'b1;
        char_out  = prefix_q;
        if (bus.out_ready) state_d = neg_q ? ST_SIGN : ST_DIGIT;
      end
      ST_SIGN: begin
        out_valid = 1'b1;
        char_out  = CHAR_MINUS;
        if (bus.out_ready) state_d = ST_DIGIT;
      end
      ST_DIGIT: begin
        out_valid = 1'b1;
        char_out  = CHAR_ZERO + {4'd0, dig[idx_q]};
        if (bus.out_ready) begin
          if (idx_q == '0) state_d = (term_q == TERM_NONE) ? ST_IDLE : ST_TERM;
          else             idx_d   = idx_q - IW'(1);
        end
      end
      ST_TERM: begin
        out_valid = 1'b1;
`ifdef NUM_CHAR_ENCODER_CRLF_EN
        char_out = (term_q == TERM_SPACE) ? CHAR_SPACE : CHAR_CR;
        if (bus.out_ready) state_d = (term_q == TERM_SPACE) ? ST_IDLE : ST_TERM_LF;
`else
        char_out = (term_q == TERM_SPACE) ? CHAR_SPACE : CHAR_LF;
        if (bus.out_ready) state_d = ST_IDLE;
`endif
      end
`ifdef NUM_CHAR_ENCODER_CRLF_EN
      ST_TERM_LF: begin
        out_valid = 1'b1;
        char_out  = CHAR_LF;
        if (bus.out_ready) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q  <= ST_IDLE;
      prefix_q <= 8'd0;
      term_q   <= TERM_NONE;
      neg_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      prefix_q <= prefix_d;
      term_q   <= term_d;
      neg_q    <= neg_d;
      idx_q    <= idx_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_valid = out_valid;
  assign bus.char_out  = char_out;
  assign bus.char_type = char_class(char_out);

endmodule
